// File: rtl/aes_block_packer.sv
// Gathers IN_W-bit state/key beats into OUT_W-bit blocks for aes_128.
// The next block can fill while the current one waits on the AES side.
module aes_block_packer #(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 128,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            key_hold,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_W-1:0]                 in_state,
    input  logic [IN_W-1:0]                 in_key,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_W-1:0]                out_state,
    output logic [OUT_W-1:0]                out_key,
    output logic [$clog2(OUT_W/IN_W)-1:0]   beat_cnt
);

    localparam int RATIO = OUT_W / IN_W;
    localparam int CW    = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_beat_cnt;
    logic [OUT_W-1:0] r_asm_state;
    logic [OUT_W-1:0] r_asm_key;
    logic [OUT_W-1:0] w_asm_state_nxt;
    logic [OUT_W-1:0] w_asm_key_nxt;
    logic             r_hold;
    logic             w_hold;
    logic             w_accept;
    logic             w_last;

    function automatic int lane_lo(input int k);
        return MSB_FIRST ? OUT_W - (k + 1) * IN_W : k * IN_W;
    endfunction

    // A flush in the same cycle as a beat discards that beat.
    assign w_accept = in_valid && in_ready && !flush;
    assign w_last   = w_accept && (r_beat_cnt == LAST);
    // key_hold is only meaningful on beat 0; later beats use the latched value.
    assign w_hold   = (r_beat_cnt == '0) ? key_hold : r_hold;
    assign beat_cnt = r_beat_cnt;

    always_comb begin
        // NOTE: defaults first so every path assigns every bit -- no latches.
        w_asm_state_nxt = r_asm_state;
        w_asm_key_nxt   = r_asm_key;
        for (int k = 0; k < RATIO; k++) begin
            if (int'(r_beat_cnt) == k) begin
                w_asm_state_nxt[lane_lo(k) +: IN_W] = in_state;
                if (!w_hold) begin
                    w_asm_key_nxt[lane_lo(k) +: IN_W] = in_key;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all sequential state.
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: if (w_last) w_state_nxt = FULL;
            FULL: begin
                if (w_last) begin
                    w_state_nxt = FULL;
                end else if (out_ready) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // The final beat may only land when the output slot is free or being freed.
    always_comb begin
        out_valid = (r_state == FULL);
        in_ready  = (r_state == FILL) || (r_beat_cnt != LAST) || out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_asm_state <= '0;
            r_asm_key   <= '0;
            r_hold      <= 1'b0;
            out_state   <= '0;
            out_key     <= '0;
        end else begin
            if (flush) begin
                r_beat_cnt  <= '0;
                r_asm_state <= '0;
                r_asm_key   <= '0;
            end else if (w_accept) begin
                r_beat_cnt  <= w_last ? '0 : r_beat_cnt + 1'b1;
                r_asm_state <= w_asm_state_nxt;
                r_asm_key   <= w_asm_key_nxt;
                if (r_beat_cnt == '0) begin
                    r_hold <= key_hold;
                end
            end
            if (w_last) begin
                out_state <= w_asm_state_nxt;
                if (!w_hold) begin
                    out_key <= w_asm_key_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: both beat orders side by side against a beat-list model.
module tb_aes_block_packer;

    localparam int IN_W  = 64;
    localparam int OUT_W = 128;
    localparam int RATIO = OUT_W / IN_W;

    localparam logic [IN_W-1:0]  S0 = 64'h0011223344556677;
    localparam logic [IN_W-1:0]  S1 = 64'h8899AABBCCDDEEFF;
    localparam logic [IN_W-1:0]  K0 = 64'h0001020304050607;
    localparam logic [IN_W-1:0]  K1 = 64'h08090A0B0C0D0E0F;
    localparam logic [OUT_W-1:0] BLK1_ST_M  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [OUT_W-1:0] BLK1_ST_L  = 128'h8899AABBCCDDEEFF0011223344556677;
    localparam logic [OUT_W-1:0] BLK1_KEY_M = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [OUT_W-1:0] BLK1_KEY_L = 128'h08090A0B0C0D0E0F0001020304050607;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic key_hold = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [IN_W-1:0] in_state = '0;
    logic [IN_W-1:0] in_key = '0;

    logic            in_ready_m, out_valid_m, in_ready_l, out_valid_l;
    logic [OUT_W-1:0] out_state_m, out_key_m, out_state_l, out_key_l;
    logic [0:0]      beat_cnt_m, beat_cnt_l;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aes_block_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .key_hold(key_hold),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_state(in_state), .in_key(in_key),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_state(out_state_m),
        .out_key(out_key_m), .beat_cnt(beat_cnt_m)
    );

    aes_block_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .key_hold(key_hold),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_state(in_state), .in_key(in_key),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_state(out_state_l),
        .out_key(out_key_l), .beat_cnt(beat_cnt_l)
    );

    task automatic check(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: list of accepted beats per block, block built by concatenation.
    bit               m_valid;
    bit               m_hold;
    int               m_n;
    logic [IN_W-1:0]  sb [RATIO];
    logic [IN_W-1:0]  kb [RATIO];
    logic [OUT_W-1:0] m_st_m, m_st_l, m_key_m, m_key_l;
    bit               exp_rdy, acc, done;
    logic [OUT_W-1:0] bsm, bsl, bkm, bkl;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_hold = 1'b0; m_n = 0;
            m_st_m = '0; m_st_l = '0; m_key_m = '0; m_key_l = '0;
            check("rst out_valid", OUT_W'(out_valid_m), '0);
            check("rst beat_cnt", OUT_W'(beat_cnt_l), '0);
            check("rst out_state", out_state_m | out_state_l, '0);
            check("rst out_key", out_key_m | out_key_l, '0);
        end else begin
            exp_rdy = !m_valid || (m_n < RATIO - 1) || out_ready;
            check("m out_valid", OUT_W'(out_valid_m), OUT_W'(m_valid));
            check("l out_valid", OUT_W'(out_valid_l), OUT_W'(m_valid));
            check("m in_ready", OUT_W'(in_ready_m), OUT_W'(exp_rdy));
            check("l in_ready", OUT_W'(in_ready_l), OUT_W'(exp_rdy));
            check("m beat_cnt", OUT_W'(beat_cnt_m), OUT_W'(m_n));
            check("l beat_cnt", OUT_W'(beat_cnt_l), OUT_W'(m_n));
            check("m out_state", out_state_m, m_st_m);
            check("l out_state", out_state_l, m_st_l);
            check("m out_key", out_key_m, m_key_m);
            check("l out_key", out_key_l, m_key_l);

            acc  = in_valid && exp_rdy && !flush;
            done = 1'b0;
            if (flush) begin
                m_n = 0;
            end else if (acc) begin
                if (m_n == 0) m_hold = key_hold;
                sb[m_n] = in_state;
                kb[m_n] = in_key;
                if (m_n == RATIO - 1) begin
                    done = 1'b1;
                    m_n = 0;
                    bsm = '0; bsl = '0; bkm = '0; bkl = '0;
                    for (int k = 0; k < RATIO; k++) begin
                        bsm = (bsm << IN_W) | OUT_W'(sb[k]);
                        bkm = (bkm << IN_W) | OUT_W'(kb[k]);
                        bsl = bsl | (OUT_W'(sb[k]) << (k * IN_W));
                        bkl = bkl | (OUT_W'(kb[k]) << (k * IN_W));
                    end
                    m_st_m = bsm;
                    m_st_l = bsl;
                    if (!m_hold) begin
                        m_key_m = bkm;
                        m_key_l = bkl;
                    end
                end else begin
                    m_n++;
                end
            end
            if (done) m_valid = 1'b1;
            else if (m_valid && out_ready) m_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IN_W-1:0] s, input logic [IN_W-1:0] k);
        in_valid = 1'b1;
        in_state = s;
        in_key   = k;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("lit reset out_valid", OUT_W'(out_valid_m), '0);
        check("lit reset beat_cnt", OUT_W'(beat_cnt_m), '0);
        rst_n = 1'b1;
        tick();

        // Basic block, both orders.
        out_ready = 1'b1;
        beat(S0, K0);
        beat(S1, K1);
        check("lit blk1 out_valid", OUT_W'(out_valid_m), OUT_W'(1'b1));
        check("lit blk1 state msb", out_state_m, BLK1_ST_M);
        check("lit blk1 state lsb", out_state_l, BLK1_ST_L);
        check("lit blk1 key msb", out_key_m, BLK1_KEY_M);
        tick();
        check("lit blk1 popped", OUT_W'(out_valid_m), '0);

        // key_hold latched on beat 0 only.
        key_hold = 1'b1;
        beat(S1, '1);
        key_hold = 1'b0;
        beat(S0, '1);
        check("lit hold key msb", out_key_m, BLK1_KEY_M);
        check("lit hold key lsb", out_key_l, BLK1_KEY_L);
        tick();

        // Backpressure: one beat of the next block slips in, then stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state = 64'h0123456789ABCDEF; in_key = in_state; tick();
        in_state = 64'hFEDCBA9876543210; in_key = in_state; tick();
        in_state = 64'hDEADBEEF00000001; in_key = in_state; tick();
        in_state = 64'hCAFEF00D00000002; in_key = in_state;
        repeat (7) tick();
        check("lit bp in_ready", OUT_W'(in_ready_m), '0);
        check("lit bp beat_cnt", OUT_W'(beat_cnt_m), OUT_W'(1'b1));
        check("lit bp state", out_state_m, 128'h0123456789ABCDEFFEDCBA9876543210);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lit b2b out_valid", OUT_W'(out_valid_m), OUT_W'(1'b1));
        check("lit b2b state", out_state_m, 128'hDEADBEEF00000001CAFEF00D00000002);
        tick();

        // Flush after beat 0, and flush colliding with a beat.
        beat(64'h1111111111111111, 64'h1111111111111111);
        check("lit pre-flush cnt", OUT_W'(beat_cnt_m), OUT_W'(1'b1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("lit flush cnt", OUT_W'(beat_cnt_m), '0);
        flush = 1'b1;
        beat(64'h2222222222222222, 64'h2222222222222222);
        flush = 1'b0;
        check("lit flush+beat cnt", OUT_W'(beat_cnt_m), '0);
        beat(64'hAAAAAAAA00000000, 64'h0);
        beat(64'h55555555FFFFFFFF, 64'h0);
        check("lit post-flush state", out_state_m, 128'hAAAAAAAA0000000055555555FFFFFFFF);
        tick();

        // Reset mid-block and while a block is presented.
        beat(S0, K0);
        #1 rst_n = 1'b0;
        #1 check("lit rst mid cnt", OUT_W'(beat_cnt_m), '0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        beat(S0, K0);
        beat(S1, K1);
        check("lit pre-rst valid", OUT_W'(out_valid_m), OUT_W'(1'b1));
        #1 rst_n = 1'b0;
        #1;
        check("lit rst out_valid", OUT_W'(out_valid_m), '0);
        check("lit rst out_state", out_state_m, '0);
        check("lit rst out_key", out_key_m, '0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        beat(S0, K0);
        beat(S1, K1);
        check("lit after-rst state", out_state_m, BLK1_ST_M);
        check("lit after-rst key", out_key_l, BLK1_KEY_L);
        tick();

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            key_hold  = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_state  = {$urandom, $urandom};
            in_key    = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
Name: aes_block_packer

Overview:
- Parametrised successor to the fixed 64-to-128 input buffer in front of aes_128.
- Gathers IN_W-bit beats of state and key into OUT_W-bit blocks and presents them to the AES core over a valid/ready handshake.
- Supports MSB-first or LSB-first beat order, key-hold mode (key captured once, reused across blocks) and a synchronous flush of partial blocks.
- Sits between the narrow source interface and aes_128.

Parameters:
IN_W, 64, beat width in bits; OUT_W must be an integer multiple, RATIO = OUT_W/IN_W >= 2
OUT_W, 128, assembled block width fed to aes_128
MSB_FIRST, 1, 1: first beat lands in bits [OUT_W-1 -: IN_W]; 0: first beat lands in bits [IN_W-1:0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous: discard partial block, counter to 0
key_hold  input  1  sampled at beat 0 of each block: 1 = keep existing key register, ignore in_key for whole block
in_valid  input  1  beat available
in_ready  output  1  packer accepts beat this cycle
in_state  input  IN_W  state beat
in_key  input  IN_W  key beat
out_valid  output  1  assembled block available
out_ready  input  1  AES side accepts block
out_state  output  OUT_W  assembled state block
out_key  output  OUT_W  assembled (or held) key block
beat_cnt  output  clog2(RATIO)  beats collected in current block (debug)

Behaviour:
- Reset (rst_n low, any time, including mid-block): beat_cnt=0, out_valid=0, out_state=0, out_key=0, hold flag=0, FSM=FILL.
- FSM states:
  - FILL: collecting beats.
  - FULL: block presented, out_valid=1.
- Beat accept = in_valid && in_ready.
  - Beat k (0..RATIO-1) is written to lane k (MSB_FIRST) or lane k counted from the LSB end (MSB_FIRST=0).
  - beat_cnt increments on each accept.
- Assembly registers are separate from the output registers. On the RATIO-th accept:
  - Completed block copies into out_state/out_key.
  - beat_cnt wraps to 0; FSM goes to FULL; out_valid=1 the next cycle.
- Latency: out_valid rises one cycle after the final beat is accepted.
- in_ready:
  - In FILL: 1.
  - In FULL: 1 while beat_cnt < RATIO-1, so the next block's first RATIO-1 beats can fill while the current block waits.
  - The final beat is accepted only if out_ready=1 that cycle or the FSM is in FILL.
- In FULL, out_ready=1 with no concurrent completing beat: out_valid drops the next cycle, FSM to FILL.
- Simultaneous out_ready=1 and final-beat accept: new block loads into the output registers, out_valid stays 1 (back-to-back, no bubble).
- out_state/out_key are stable while out_valid=1 && out_ready=0.
- key_hold:
  - Latched at the beat-0 accept.
  - When latched 1: key assembly lanes are not written for that block, and out_key repeats the previous block's key.
  - key_hold=1 on the first block after reset yields out_key=0.
- flush:
  - Clears beat_cnt and the assembly registers.
  - Does not affect a block already in FULL.
  - flush and a beat accept in the same cycle: flush wins, beat discarded.
- Bus-width arithmetic: no truncation or extension; every output bit comes from exactly one beat.

Test Plan:
- Defaults, MSB_FIRST=1, beats state 0x0011223344556677 then 0x8899AABBCCDDEEFF, key 0x0001020304050607 then 0x08090A0B0C0D0E0F, out_ready=1 -> one cycle after beat 2: out_valid=1, out_state=0x00112233445566778899AABBCCDDEEFF, out_key=0x000102030405060708090A0B0C0D0E0F.
- MSB_FIRST=0, same beats -> out_state=0x8899AABBCCDDEEFF0011223344556677.
- out_ready=0 for 10 cycles with in_valid continuously high -> one beat of the next block accepted, then in_ready=0; outputs stable. Raising out_ready -> second block completes with out_valid held high (no bubble).
- key_hold=1 on block 2 with in_key=0xFFFF..FF -> block 2 out_key equals block 1 key 0x000102030405060708090A0B0C0D0E0F.
- Beat 0 accepted, then flush -> beat_cnt=0. Next two beats form a block containing only the new data.
- rst_n low after beat 0 and while out_valid=1 -> out_valid=0 immediately, all outputs 0, beat_cnt=0. After release, a full block assembles correctly.
